tdt_icg_en_ctrl: RTL and testbench
==================================

# tdt_icg_en_ctrl

Clock-enable controller that drives the `module_en` input of a downstream gated clock cell. It watches a functional unit's activity, withdraws the enable after a programmable run of idle cycles, and restores it on a wake request through a req/ack handshake. The ack is issued only after the gated clock has had a guaranteed settle window. The block sits on the always-on clock beside each gated functional unit. It is the enable-producing end of the gated-clock-cell interface.

## Interface
Parameters:
- `IDLE_THRESH`, default 8: consecutive idle cycles before gating off. Legal range 1 .. 2^CNT_W-1.
- `WAKE_DLY`, default 2: cycles the enable is held before a wake is acknowledged. Legal range 1 .. 2^CNT_W-1.
- `CNT_W`, default 4: width of the shared idle/wake counter.

Ports:
- `forever_cpuclk`  in  1  ungated clock. This is the only clock.
- `cpurst_b`  in  1  reset, asynchronous, active-low.
- `cp0_yy_clk_en`  in  1  CSR gating permission. 0 means gating is disabled and the enable is held on.
- `pad_yy_icg_scan_en`  in  1  scan mode. 1 means the enable is forced on and the FSM is held.
- `unit_busy`  in  1  activity indication from the gated unit.
- `wake_req`  in  1  level wake request. Held until `wake_ack` is seen.
- `wake_ack`  out  1  one-cycle wake acknowledge. Registered.
- `module_en`  out  1  enable to the gated clock cell. Registered.
- `clk_idle`  out  1  1 while the unit clock is gated off. Registered.

## Operation
- States: ON, OFF, WAKE. One counter `cnt[CNT_W-1:0]` is shared between the idle and wake phases.
- The idle condition is `!unit_busy && !wake_req && cp0_yy_clk_en && !pad_yy_icg_scan_en`.
- ON:
  - On each idle edge, `cnt` increments.
  - On any non-idle edge, `cnt` clears to 0.
  - If `cnt == IDLE_THRESH-1` on an idle edge, the FSM goes to OFF and `cnt` clears to 0.
- OFF:
  - If `unit_busy` or `wake_req` is sampled high, the FSM goes to WAKE and `cnt` clears to 0.
  - If `cp0_yy_clk_en == 0` or `pad_yy_icg_scan_en == 1`, the FSM goes directly to ON, skipping WAKE.
- WAKE:
  - `cnt` increments each cycle.
  - If `cnt == WAKE_DLY-1`, the FSM goes to ON and `cnt` clears to 0.
  - Scan mode or CSR disable also forces the FSM to ON.
- `module_en` next value is 1 for next state ON or WAKE, and 0 for next state OFF.
- `clk_idle` next value is 1 only when the next state is OFF.
- `wake_ack` next value is `wake_req && !wake_ack && (next state == ON)`.
  - A request raised while in ON is acked on the next edge.
  - A request that caused WAKE is acked on the WAKE-to-ON edge.
  - An ack never repeats for the same held request, because the requester drops `wake_req` in the cycle after it sees the ack.
  - A request still high two cycles after its ack is treated as a new request.
- Scan precedence: while `pad_yy_icg_scan_en` is 1, the FSM is held in ON, `cnt` is held at 0, and `module_en` is 1. Wake handshakes still complete.
- Simultaneous events:
  - If `unit_busy` and the idle threshold coincide, busy wins: the FSM stays in ON and `cnt` clears.
  - A `wake_req` arriving in WAKE is merged with the wake in progress and receives one ack at WAKE exit.

## Timing
- Reset (asynchronous assert, synchronous release by `forever_cpuclk`):
  - State ON, `cnt` = 0.
  - `module_en` = 1, `wake_ack` = 0, `clk_idle` = 0.
  - Reset mid-WAKE or mid-OFF drops immediately to these values, and no ack is issued.
- Gate-off latency: `module_en` falls after the IDLE_THRESH-th consecutive idle edge.
- Wake latency from OFF: `module_en` rises 1 edge after `wake_req` or `unit_busy` is sampled. `wake_ack` rises WAKE_DLY edges after that.
- Wake latency from ON: `wake_ack` rises 1 edge after `wake_req` is sampled.
- All outputs are flop outputs. There is no combinational path from input to output.

## Test plan
- Reset, then hold `unit_busy` = 0, `wake_req` = 0, `cp0_yy_clk_en` = 1 (IDLE_THRESH = 8). Required: `module_en` = 1 through edge 7, then `module_en` = 0 and `clk_idle` = 1 after edge 8.
- Idle for 7 edges, then `unit_busy` = 1 for 1 cycle, then idle again. Required: no gate-off until 8 further idle edges.
- In OFF, raise `wake_req` at edge E (WAKE_DLY = 2). Required: `module_en` = 1 after E; `wake_ack` = 1 for exactly one cycle after E+2; `clk_idle` = 0 after E.
- In ON, raise `wake_req` and drop it the cycle after the ack. Required: ack after 1 edge, exactly one ack pulse, `cnt` cleared.
- In OFF, drive `pad_yy_icg_scan_en` = 1, then separately `cp0_yy_clk_en` = 0. Required: `module_en` = 1 after the next edge, no WAKE state, and the FSM holds ON regardless of `unit_busy`.
- Assert `cpurst_b` = 0 midway through WAKE. Required: outputs are immediately 1/0/0 (`module_en`/`wake_ack`/`clk_idle`), no ack after release, and the idle count restarts from 0.

Source files
------------

// File: rtl/tdt_icg_en_ctrl.sv
// ---------------------------------------------------------------------------
// tdt_icg_en_ctrl
//
// Produces the module_en input of a downstream gated clock cell. The enable
// is withdrawn after IDLE_THRESH consecutive idle cycles of the functional
// unit and restored on unit activity or a wake request. A wake request that
// found the clock gated off is acknowledged only after the enable has been
// held for WAKE_DLY cycles, so the gated clock has settled before the
// requester proceeds. Runs on the always-on clock.
//
// Ports:
//   forever_cpuclk      in   ungated clock (only clock)
//   cpurst_b            in   asynchronous active-low reset
//   cp0_yy_clk_en       in   CSR gating permission (0: enable held on)
//   pad_yy_icg_scan_en  in   scan mode (1: enable forced on, FSM held in ON)
//   unit_busy           in   activity indication from the gated unit
//   wake_req            in   level wake request, held until wake_ack seen
//   wake_ack            out  one-cycle wake acknowledge (registered)
//   module_en           out  enable to the gated clock cell (registered)
//   clk_idle            out  1 while the unit clock is gated off (registered)
// ---------------------------------------------------------------------------
module tdt_icg_en_ctrl #(
    parameter int IDLE_THRESH = 8,
    parameter int WAKE_DLY    = 2,
    parameter int CNT_W       = 4
) (
    input  logic forever_cpuclk,
    input  logic cpurst_b,
    input  logic cp0_yy_clk_en,
    input  logic pad_yy_icg_scan_en,
    input  logic unit_busy,
    input  logic wake_req,
    output logic wake_ack,
    output logic module_en,
    output logic clk_idle
);

    typedef enum logic [1:0] {
        ST_ON   = 2'b00,
        ST_OFF  = 2'b01,
        ST_WAKE = 2'b10
    } state_e;

    // Terminal counts of the shared counter for the idle and wake phases.
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_THRESH - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_DLY - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_r;
    state_e           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             force_on_s;
    logic             idle_s;
    logic             wake_ev_s;
    logic             ack_nxt_s;

    // Decode of the input conditions that steer the FSM.
    always_comb begin
        force_on_s = pad_yy_icg_scan_en | ~cp0_yy_clk_en;
        wake_ev_s  = unit_busy | wake_req;
        idle_s     = ~unit_busy & ~wake_req & cp0_yy_clk_en & ~pad_yy_icg_scan_en;
    end

    // Next-state and shared-counter logic.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_ON: begin
                // Any non-idle cycle (including busy on the threshold cycle,
                // scan and CSR disable) restarts the idle run.
                if (!idle_s) begin
                    state_nxt_s = ST_ON;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == IDLE_LAST) begin
                    state_nxt_s = ST_OFF;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = ST_ON;
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            ST_OFF: begin
                // Scan or CSR disable bypasses the settle window entirely.
                if (force_on_s) begin
                    state_nxt_s = ST_ON;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (wake_ev_s) begin
                    state_nxt_s = ST_WAKE;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = ST_OFF;
                    cnt_nxt_s   = CNT_ZERO;
                end
            end
            ST_WAKE: begin
                if (force_on_s || (cnt_r == WAKE_LAST)) begin
                    state_nxt_s = ST_ON;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = ST_WAKE;
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_ON;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
        // Ack only once the unit is fully awake; the !wake_ack term blocks
        // a second pulse on the cycle the requester is still dropping.
        ack_nxt_s = wake_req & ~wake_ack & (state_nxt_s == ST_ON);
    end

    // FSM state, counter and registered outputs.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_r   <= ST_ON;
            cnt_r     <= CNT_ZERO;
            module_en <= 1'b1;
            wake_ack  <= 1'b0;
            clk_idle  <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            module_en <= (state_nxt_s != ST_OFF);
            wake_ack  <= ack_nxt_s;
            clk_idle  <= (state_nxt_s == ST_OFF);
        end
    end

endmodule

// File: tb/tb_tdt_icg_en_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for tdt_icg_en_ctrl: a table of directed vectors, hand-written
// reset sequences, then randomized stimulus against a behavioural model.
// ---------------------------------------------------------------------------
module tb_tdt_icg_en_ctrl;

    localparam int IDLE_THRESH = 8;
    localparam int WAKE_DLY    = 2;
    localparam int CNT_W       = 4;
    localparam int N_RAND      = 3000;

    logic clk;
    logic rst_n;
    logic csr_en;
    logic scan_en;
    logic busy;
    logic req;
    logic ack;
    logic en;
    logic idle;

    int vec_cnt;
    int err_cnt;

    // Behavioural model: gated flag, remaining settle cycles, idle run length.
    bit m_gated;
    int m_wake_left;
    int m_run;
    bit m_ack;

    typedef struct {
        logic       b;
        logic       r;
        logic       c;
        logic       s;
        logic [2:0] exp;  // {module_en, wake_ack, clk_idle}
    } vec_t;

    vec_t tbl[$];

    tdt_icg_en_ctrl #(
        .IDLE_THRESH(IDLE_THRESH),
        .WAKE_DLY   (WAKE_DLY),
        .CNT_W      (CNT_W)
    ) dut (
        .forever_cpuclk    (clk),
        .cpurst_b          (rst_n),
        .cp0_yy_clk_en     (csr_en),
        .pad_yy_icg_scan_en(scan_en),
        .unit_busy         (busy),
        .wake_req          (req),
        .wake_ack          (ack),
        .module_en         (en),
        .clk_idle          (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic b, input logic r, input logic c, input logic s,
                       input logic e_en, input logic e_ack, input logic e_idle);
        vec_t v;
        v.b = b; v.r = r; v.c = c; v.s = s;
        v.exp = {e_en, e_ack, e_idle};
        tbl.push_back(v);
    endtask

    task automatic add_idle(input int n, input logic e_en, input logic e_idle);
        for (int i = 0; i < n; i++) add(1'b0, 1'b0, 1'b1, 1'b0, e_en, 1'b0, e_idle);
    endtask

    task automatic check(input string name, input logic [2:0] exp);
        vec_cnt++;
        if ({en, ack, idle} !== exp) begin
            err_cnt++;
            $display("FAIL %s @%0t: en/ack/idle got %b required %b", name, $time, {en, ack, idle}, exp);
        end
    endtask

    task automatic model_reset();
        m_gated     = 1'b0;
        m_wake_left = 0;
        m_run       = 0;
        m_ack       = 1'b0;
    endtask

    // One clock edge of the reference behaviour given the sampled inputs.
    task automatic model_step(input logic b, input logic r, input logic c, input logic s);
        bit forced;
        bit quiet;
        forced = s || !c;
        quiet  = !b && !r && c && !s;
        if (m_wake_left > 0) begin
            m_wake_left = forced ? 0 : m_wake_left - 1;
        end else if (m_gated) begin
            if (forced) m_gated = 1'b0;
            else if (b || r) begin
                m_gated     = 1'b0;
                m_wake_left = WAKE_DLY;
            end
        end else begin
            if (quiet) begin
                m_run++;
                if (m_run == IDLE_THRESH) begin
                    m_gated = 1'b1;
                    m_run   = 0;
                end
            end else begin
                m_run = 0;
            end
        end
        m_ack = r && !m_ack && !m_gated && (m_wake_left == 0);
    endtask

    function automatic logic [2:0] model_out();
        return {!m_gated, m_ack, m_gated};
    endfunction

    // Drive at the falling edge, then sample 1 time unit after the rising edge.
    task automatic apply(input logic b, input logic r, input logic c, input logic s);
        @(negedge clk);
        busy = b; req = r; csr_en = c; scan_en = s;
        @(posedge clk);
        #1;
        model_step(b, r, c, s);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] exp_v;
        vec_cnt = 0;
        err_cnt = 0;
        rst_n = 1'b0; busy = 1'b0; req = 1'b0; csr_en = 1'b1; scan_en = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_values", 3'b100);
        rst_n = 1'b1;

        // Directed table: gate-off, wake from OFF, wake from ON, busy vs
        // threshold, scan and CSR overrides, re-request after ack.
        add_idle(IDLE_THRESH - 1, 1'b1, 1'b0);
        add_idle(1, 1'b0, 1'b1);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);  // wake from OFF
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);  // ack after WAKE_DLY
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);  // wake from ON
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add_idle(6, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);  // busy on threshold
        add_idle(IDLE_THRESH - 1, 1'b1, 1'b0);
        add_idle(1, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);  // scan from OFF
        add(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        add_idle(IDLE_THRESH - 1, 1'b1, 1'b0);
        add_idle(1, 1'b0, 1'b1);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);  // CSR off: no WAKE delay
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);  // held request re-acked
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].b, tbl[i].r, tbl[i].c, tbl[i].s);
            check($sformatf("table[%0d]", i), tbl[i].exp);
        end

        // Reset while OFF: enable must return immediately.
        for (int i = 0; i < IDLE_THRESH; i++) apply(1'b0, 1'b0, 1'b1, 1'b0);
        check("gate_off_before_reset", 3'b001);
        #2 rst_n = 1'b0;
        #1 check("reset_mid_off", 3'b100);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();

        // Reset mid-WAKE: no ack afterwards and the idle run restarts.
        for (int i = 0; i < IDLE_THRESH; i++) apply(1'b0, 1'b0, 1'b1, 1'b0);
        apply(1'b0, 1'b1, 1'b1, 1'b0);
        check("enter_wake", 3'b100);
        #2 rst_n = 1'b0;
        req = 1'b0;
        #1 check("reset_mid_wake", 3'b100);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < IDLE_THRESH - 1; i++) begin
            apply(1'b0, 1'b0, 1'b1, 1'b0);
            check($sformatf("post_reset_idle[%0d]", i), 3'b100);
        end
        apply(1'b0, 1'b0, 1'b1, 1'b0);
        check("post_reset_gate_off", 3'b001);

        // Randomized stimulus against the model.
        for (int i = 0; i < N_RAND; i++) begin
            logic b, r, c, s;
            b = ($urandom_range(0, 31) == 0);
            r = ($urandom_range(0, 19) == 0);
            c = ($urandom_range(0, 49) != 0);
            s = ($urandom_range(0, 49) == 0);
            apply(b, r, c, s);
            exp_v = model_out();
            check($sformatf("random[%0d]", i), exp_v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
